playseq_jogador_auto: RTL and testbench
=======================================

# playseq_jogador_auto

Automatic player for the PlaySeq game, the counterpart of the game's LED/button interface. It watches the game's `leds` output while the game signals its preview phase, stores each one-hot LED pattern shown, and then replays the stored sequence on `botoes` with fixed press and release durations. It sits beside the game top level in the 1 kHz `clock` domain. It drives the game's `botoes` input through a board-level mux, for self-test and demo.

## Interface
- `PROFUNDIDADE`, 16: sequence buffer depth, in entries.
- `T_INICIO`, 200: cycles from the end of preview to the first press. Range 1..65535.
- `T_PRESS`, 100: cycles each button is held. Range 1..65535.
- `T_GAP`, 100: cycles of `botoes`=0 after each press. Range 1..65535.

- `clock` in 1: single clock, rising edge (1 kHz game clock).
- `reset` in 1: asynchronous, active-low.
- `habilita` in 1: enables the player. 0 forces INATIVO on the next edge.
- `fase_preview` in 1: high while the game is showing the sequence.
- `leds` in 4: game LED outputs.
- `botoes` out 4: button presses to the game. Registered.
- `ocupado` out 1: high in ESPERA_INICIO, PRESSIONA and SOLTA.
- `n_capturados` out 5: number of entries stored in the current round.
- `overflow` out 1: a capture was attempted with the buffer full. Sticky until the next preview.
- `erro_padrao` out 1: a non-one-hot nonzero pattern was seen. Sticky until the next preview.
- `rodadas` out 8: count of completed playbacks. Wraps 255→0.
- `db_estado` out 3: state code (see Operation).

## Operation
- Edge detector: `leds_d` registers `leds` every cycle.
  - Capture event: `leds`≠0 and `leds_d`==0, in state ESPERA_PREVIEW with `fase_preview`=1, or in state CAPTURA.
  - One-hot pattern: written to `mem[n_capturados]`; `n_capturados`+1.
  - Non-one-hot pattern: not stored; `erro_padrao`=1.
  - Buffer full (`n_capturados`==PROFUNDIDADE): not stored; `overflow`=1.
- States (`db_estado`):
  - INATIVO = 0
  - ESPERA_PREVIEW = 1
  - CAPTURA = 2
  - ESPERA_INICIO = 3
  - PRESSIONA = 4
  - SOLTA = 5
- INATIVO: `botoes`=0. Goes to ESPERA_PREVIEW when `habilita`=1.
- ESPERA_PREVIEW: on `fase_preview`=1, clear `n_capturados`, `overflow` and `erro_padrao`, and go to CAPTURA. A capture event in the same cycle is stored at index 0 (the clear takes priority, then the write).
- CAPTURA: on `fase_preview`=0:
  - `n_capturados`==0: go to ESPERA_PREVIEW.
  - Otherwise: clear the timer and go to ESPERA_INICIO.
- ESPERA_INICIO: after T_INICIO cycles, set `idx`=0 and go to PRESSIONA.
- PRESSIONA: `botoes`=`mem[idx]` for T_PRESS cycles, then go to SOLTA.
- SOLTA: `botoes`=0 for T_GAP cycles, then:
  - `idx`+1==`n_capturados`: `rodadas`+1 and go to ESPERA_PREVIEW.
  - Otherwise: `idx`+1 and go to PRESSIONA.
- Abort: `fase_preview`=1 in ESPERA_INICIO, PRESSIONA or SOLTA means a new round has started. Go to CAPTURA with the ESPERA_PREVIEW clear semantics. `botoes`=0 from the next edge. `rodadas` is unchanged.
- `habilita`=0 in any state: go to INATIVO and set `botoes`=0 on the next edge. Buffer and flags are retained.
- Widths: timer 16 bits, counts 0..T−1. `idx` is 4 bits. `n_capturados` is 5 bits and saturates at PROFUNDIDADE.

## Timing
- Reset (asynchronous, `reset`=0) values:
  - state INATIVO
  - `botoes`=0, `ocupado`=0
  - `n_capturados`=0, `overflow`=0, `erro_padrao`=0
  - `rodadas`=0, `db_estado`=0
  - `leds_d`=0
  - Buffer contents are don't-care.
- Reset mid-playback: `botoes`=0 immediately (asynchronous).
- Capture latency: `n_capturados` updates on the edge after the cycle in which the rising `leds` pattern is sampled.
- From the first edge with `fase_preview`=0 in CAPTURA to the first nonzero `botoes`: exactly T_INICIO+1 cycles.
- Each press: `botoes` nonzero for exactly T_PRESS consecutive cycles, then 0 for exactly T_GAP cycles.
- A full playback of N entries after preview ends takes 1 + T_INICIO + N·(T_PRESS+T_GAP) cycles, ending in ESPERA_PREVIEW.
- A steady LED held over several cycles is captured once. The same pattern repeated requires an intervening `leds`=0.

## Test plan
All tests use T_INICIO=4, T_PRESS=3, T_GAP=2.
- Basic round: `habilita`=1; preview shows 0001, 0100, 1000, each separated by 0000, then `fase_preview` falls.
  - Required: `n_capturados`=3.
  - Required: `botoes` = 0001×3, 0×2, 0100×3, 0×2, 1000×3, 0×2, first press 5 cycles after the fall.
  - Required: `rodadas`=1 and `db_estado`=1 at the end.
- Overflow: 17 distinct captures in one preview.
  - Required: `n_capturados`=16, `overflow`=1, and 16 presses played.
  - Required: the next preview clears `overflow`.
- Bad pattern: `leds`=0110 during preview.
  - Required: `erro_padrao`=1, `n_capturados` unchanged, and that entry is never played.
- Abort: `fase_preview` rises during the second press.
  - Required: `botoes`=0 next cycle, `db_estado`=2, `n_capturados`=0, `rodadas` unchanged.
- Disable and reset:
  - `habilita`=0 during PRESSIONA: state INATIVO and `botoes`=0 on the next edge.
  - `reset`=0 mid-playback: all outputs at reset values asynchronously.
- Empty preview: `fase_preview` pulses with `leds` held at 0.
  - Required: return to ESPERA_PREVIEW, `botoes` stays 0, `rodadas` unchanged.

Source files
------------

// File: rtl/playseq_jogador_auto.sv
`default_nettype none
// ============================================================================
// Module      : playseq_jogador_auto
// Description : Automatic PlaySeq player. Records the one-hot LED patterns
//               shown during the game's preview phase and replays them on
//               the button outputs with fixed press/release timing.
// Revision    : 1.0 - initial release
// ============================================================================
module playseq_jogador_auto #(
    parameter int PROFUNDIDADE = 16,
    parameter int T_INICIO     = 200,
    parameter int T_PRESS      = 100,
    parameter int T_GAP        = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       fase_preview,
    input  logic [3:0] leds,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic [4:0] n_capturados,
    output logic       overflow,
    output logic       erro_padrao,
    output logic [7:0] rodadas,
    output logic [2:0] db_estado
);

    localparam logic [2:0] c_INATIVO        = 3'd0;
    localparam logic [2:0] c_ESPERA_PREVIEW = 3'd1;
    localparam logic [2:0] c_CAPTURA        = 3'd2;
    localparam logic [2:0] c_ESPERA_INICIO  = 3'd3;
    localparam logic [2:0] c_PRESSIONA      = 3'd4;
    localparam logic [2:0] c_SOLTA          = 3'd5;

    // Terminal counts: the timer runs 0..T-1 in each timed state
    localparam logic [15:0] c_FIM_INICIO = 16'(T_INICIO - 1);
    localparam logic [15:0] c_FIM_PRESS  = 16'(T_PRESS - 1);
    localparam logic [15:0] c_FIM_GAP    = 16'(T_GAP - 1);
    localparam logic [4:0]  c_CHEIO      = 5'(PROFUNDIDADE);

    logic [2:0]  r_state;
    logic [3:0]  r_leds_d;
    logic [15:0] r_timer;
    logic [3:0]  r_idx;
    logic [3:0]  r_botoes;
    logic [4:0]  r_n_capturados;
    logic        r_overflow;
    logic        r_erro_padrao;
    logic [7:0]  r_rodadas;
    logic [3:0]  r_mem [PROFUNDIDADE];

    logic        w_subida;
    logic        w_one_hot;
    logic        w_tocando;
    logic        w_abort;
    logic        w_limpa;
    logic        w_captura;
    logic [4:0]  w_base;
    logic        w_cheio;
    logic        w_grava;
    logic        w_ultimo;

    // Capture qualification and round-clear decode
    always_comb begin
        w_subida  = (leds != 4'd0) && (r_leds_d == 4'd0);
        w_one_hot = ((leds & (leds - 4'd1)) == 4'd0);
        w_tocando = (r_state == c_ESPERA_INICIO) || (r_state == c_PRESSIONA) ||
                    (r_state == c_SOLTA);
        // A disabled player leaves buffer and flags untouched
        w_abort   = habilita && fase_preview && w_tocando;
        w_limpa   = w_abort ||
                    (habilita && fase_preview && (r_state == c_ESPERA_PREVIEW));
        w_captura = habilita && w_subida &&
                    (((r_state == c_ESPERA_PREVIEW) && fase_preview) ||
                     (r_state == c_CAPTURA));
        // Clear first, then write: a capture coinciding with the clear lands at 0
        w_base    = w_limpa ? 5'd0 : r_n_capturados;
        w_cheio   = (w_base == c_CHEIO);
        w_grava   = w_captura && w_one_hot && !w_cheio;
        w_ultimo  = (({1'b0, r_idx} + 5'd1) == r_n_capturados);
    end

    // Sequence buffer; contents need no reset
    always_ff @(posedge clock) begin
        if (w_grava) begin
            r_mem[w_base[3:0]] <= leds;
        end
    end

    // Capture count and sticky error flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_n_capturados <= 5'd0;
            r_overflow     <= 1'b0;
            r_erro_padrao  <= 1'b0;
        end else begin
            if (w_limpa) begin
                r_n_capturados <= 5'd0;
                r_overflow     <= 1'b0;
                r_erro_padrao  <= 1'b0;
            end
            if (w_captura) begin
                if (!w_one_hot) begin
                    r_erro_padrao <= 1'b1;
                end else if (w_cheio) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_n_capturados <= w_base + 5'd1;
                end
            end
        end
    end

    // Main state machine, playback timer and registered button drive
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= c_INATIVO;
            r_leds_d  <= 4'd0;
            r_timer   <= 16'd0;
            r_idx     <= 4'd0;
            r_botoes  <= 4'd0;
            r_rodadas <= 8'd0;
        end else begin
            r_leds_d <= leds;
            if (!habilita) begin
                r_state  <= c_INATIVO;
                r_botoes <= 4'd0;
            end else if (w_abort) begin
                r_state  <= c_CAPTURA;
                r_botoes <= 4'd0;
            end else begin
                case (r_state)
                    c_INATIVO: begin
                        r_botoes <= 4'd0;
                        r_state  <= c_ESPERA_PREVIEW;
                    end
                    c_ESPERA_PREVIEW: begin
                        if (fase_preview) begin
                            r_state <= c_CAPTURA;
                        end
                    end
                    c_CAPTURA: begin
                        if (!fase_preview) begin
                            if (r_n_capturados == 5'd0) begin
                                r_state <= c_ESPERA_PREVIEW;
                            end else begin
                                r_timer <= 16'd0;
                                r_state <= c_ESPERA_INICIO;
                            end
                        end
                    end
                    c_ESPERA_INICIO: begin
                        if (r_timer == c_FIM_INICIO) begin
                            r_timer  <= 16'd0;
                            r_idx    <= 4'd0;
                            r_botoes <= r_mem[0];
                            r_state  <= c_PRESSIONA;
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                    c_PRESSIONA: begin
                        if (r_timer == c_FIM_PRESS) begin
                            r_timer  <= 16'd0;
                            r_botoes <= 4'd0;
                            r_state  <= c_SOLTA;
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                    c_SOLTA: begin
                        if (r_timer == c_FIM_GAP) begin
                            r_timer <= 16'd0;
                            if (w_ultimo) begin
                                r_rodadas <= r_rodadas + 8'd1;
                                r_state   <= c_ESPERA_PREVIEW;
                            end else begin
                                r_idx    <= r_idx + 4'd1;
                                r_botoes <= r_mem[r_idx + 4'd1];
                                r_state  <= c_PRESSIONA;
                            end
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                    default: begin
                        r_botoes <= 4'd0;
                        r_state  <= c_INATIVO;
                    end
                endcase
            end
        end
    end

    assign botoes       = r_botoes;
    assign ocupado      = w_tocando;
    assign n_capturados = r_n_capturados;
    assign overflow     = r_overflow;
    assign erro_padrao  = r_erro_padrao;
    assign rodadas      = r_rodadas;
    assign db_estado    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_playseq_jogador_auto.sv
`default_nettype none
// ============================================================================
// Module      : tb_playseq_jogador_auto
// Description : Directed self-checking bench for playseq_jogador_auto
//               (T_INICIO=4, T_PRESS=3, T_GAP=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_playseq_jogador_auto;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       habilita = 1'b0;
    logic       fase_preview = 1'b0;
    logic [3:0] leds = 4'd0;
    logic [3:0] botoes;
    logic       ocupado;
    logic [4:0] n_capturados;
    logic       overflow;
    logic       erro_padrao;
    logic [7:0] rodadas;
    logic [2:0] db_estado;

    int         n_checks = 0;
    int         n_fails  = 0;
    int         n_press;
    logic [3:0] played [32];
    logic [3:0] pat;

    playseq_jogador_auto #(
        .PROFUNDIDADE (16),
        .T_INICIO     (4),
        .T_PRESS      (3),
        .T_GAP        (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .habilita     (habilita),
        .fase_preview (fase_preview),
        .leds         (leds),
        .botoes       (botoes),
        .ocupado      (ocupado),
        .n_capturados (n_capturados),
        .overflow     (overflow),
        .erro_padrao  (erro_padrao),
        .rodadas      (rodadas),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One LED flash followed by a dark cycle
    task automatic show(input logic [3:0] p);
        leds = p;
        tick();
        leds = 4'd0;
        tick();
    endtask

    // Wait (bounded) for the buttons to show the given nonzero value
    task automatic wait_botoes(input logic [3:0] val);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (botoes == val) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_botoes", 32'(ok), 32'd1);
    endtask

    // Run a playback to its end, recording each press pattern
    task automatic playback();
        logic [3:0] prev = 4'd0;
        bit done = 1'b0;
        n_press = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (botoes != 4'd0 && prev == 4'd0 && n_press < 32) begin
                played[n_press] = botoes;
                n_press++;
            end
            prev = botoes;
            if (db_estado == 3'd1) begin
                done = 1'b1;
                break;
            end
        end
        check("playback_end", 32'(done), 32'd1);
    endtask

    initial begin
        logic [3:0] exp_seq [15] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                                     4'h4, 4'h4, 4'h4, 4'h0, 4'h0,
                                     4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
        int lat;

        // Reset values
        #3;
        check("rst_botoes", 32'(botoes), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_n", 32'(n_capturados), 32'd0);
        check("rst_flags", {30'd0, overflow, erro_padrao}, 32'd0);
        check("rst_rodadas", 32'(rodadas), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);
        tick();
        reset = 1'b1;
        habilita = 1'b1;
        tick();
        check("enable_estado", 32'(db_estado), 32'd1);

        // Basic round
        fase_preview = 1'b1;
        tick();
        check("captura_estado", 32'(db_estado), 32'd2);
        show(4'b0001);
        show(4'b0100);
        show(4'b1000);
        check("basic_n", 32'(n_capturados), 32'd3);
        fase_preview = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (botoes != 4'd0) begin
                lat = i;
                break;
            end
        end
        check("first_press_latency", 32'(lat), 32'd5);
        check("ocupado_play", 32'(ocupado), 32'd1);
        check("seq_0", 32'(botoes), 32'(exp_seq[0]));
        for (int i = 1; i < 15; i++) begin
            tick();
            check($sformatf("seq_%0d", i), 32'(botoes), 32'(exp_seq[i]));
        end
        tick();
        check("basic_rodadas", 32'(rodadas), 32'd1);
        check("basic_end_estado", 32'(db_estado), 32'd1);
        check("basic_end_botoes", 32'(botoes), 32'd0);

        // Overflow: 17 captures into a 16-entry buffer
        fase_preview = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            pat = 4'd1 << (i % 4);
            show(pat);
        end
        check("ovf_n", 32'(n_capturados), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_err", 32'(erro_padrao), 32'd0);
        fase_preview = 1'b0;
        playback();
        check("ovf_presses", 32'(n_press), 32'd16);
        for (int i = 0; i < 16; i++) begin
            pat = 4'd1 << (i % 4);
            check($sformatf("ovf_pat_%0d", i), 32'(played[i]), 32'(pat));
        end
        check("ovf_rodadas", 32'(rodadas), 32'd2);

        // Next preview clears overflow; bad pattern is flagged and skipped
        fase_preview = 1'b1;
        tick();
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("clear_n", 32'(n_capturados), 32'd0);
        show(4'b0010);
        show(4'b0110);
        show(4'b1000);
        check("bad_err", 32'(erro_padrao), 32'd1);
        check("bad_n", 32'(n_capturados), 32'd2);
        fase_preview = 1'b0;
        playback();
        check("bad_presses", 32'(n_press), 32'd2);
        check("bad_pat_0", 32'(played[0]), 32'h2);
        check("bad_pat_1", 32'(played[1]), 32'h8);
        check("bad_rodadas", 32'(rodadas), 32'd3);

        // Abort during the second press
        fase_preview = 1'b1;
        tick();
        show(4'b0001);
        show(4'b0010);
        fase_preview = 1'b0;
        wait_botoes(4'b0010);
        tick();
        fase_preview = 1'b1;
        tick();
        check("abort_botoes", 32'(botoes), 32'd0);
        check("abort_estado", 32'(db_estado), 32'd2);
        check("abort_n", 32'(n_capturados), 32'd0);
        check("abort_rodadas", 32'(rodadas), 32'd3);

        // Empty preview returns to waiting without playing
        fase_preview = 1'b0;
        tick();
        check("empty_estado_a", 32'(db_estado), 32'd1);
        fase_preview = 1'b1;
        tick();
        fase_preview = 1'b0;
        tick();
        check("empty_estado_b", 32'(db_estado), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("empty_botoes", 32'(botoes), 32'd0);
        end
        check("empty_rodadas", 32'(rodadas), 32'd3);

        // Disable during a press
        fase_preview = 1'b1;
        tick();
        show(4'b0100);
        show(4'b0001);
        fase_preview = 1'b0;
        wait_botoes(4'b0100);
        habilita = 1'b0;
        tick();
        check("dis_estado", 32'(db_estado), 32'd0);
        check("dis_botoes", 32'(botoes), 32'd0);
        check("dis_n_kept", 32'(n_capturados), 32'd2);
        habilita = 1'b1;
        tick();
        check("reenable_estado", 32'(db_estado), 32'd1);

        // Asynchronous reset mid-playback
        fase_preview = 1'b1;
        tick();
        show(4'b1000);
        fase_preview = 1'b0;
        wait_botoes(4'b1000);
        #2;
        reset = 1'b0;
        #1;
        check("arst_botoes", 32'(botoes), 32'd0);
        check("arst_estado", 32'(db_estado), 32'd0);
        check("arst_ocupado", 32'(ocupado), 32'd0);
        check("arst_n", 32'(n_capturados), 32'd0);
        check("arst_rodadas", 32'(rodadas), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
